// File: rtl/line_fetch.sv
// Avalon-MM read master that prefetches one grid row into a ping-pong line buffer
// while the renderer reads the other bank with a fixed 1-cycle latency.
module line_fetch #(
    parameter int unsigned GRID_W    = 320,
    parameter logic [22:0] BASE_ADDR = 23'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        line_start,
    input  logic [8:0]  fetch_row,
    output logic [22:0] address,
    output logic        read,
    input  logic        waitrequest,
    input  logic [7:0]  readdata,
    input  logic [9:0]  rd_col,
    output logic [7:0]  rd_data,
    output logic        busy,
    output logic        underrun,
    input  logic        clear_err
);

    localparam int unsigned AW = 23;
    localparam int unsigned CW = 10;
    localparam int unsigned IW = (GRID_W > 1) ? $clog2(GRID_W) : 1;
    localparam logic [CW:0]   COL_LIM  = (CW + 1)'(GRID_W);
    localparam logic [CW-1:0] COL_LAST = CW'(GRID_W - 1);

    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

    state_t          state_q;
    logic            wr_bank_q;
    logic [CW-1:0]   col_q;
    logic [AW-1:0]   row_base_q;
    logic [7:0]      bank0 [GRID_W];
    logic [7:0]      bank1 [GRID_W];

    logic [AW-1:0]   new_base_c;
    logic            xfer_c;
    logic            done_c;

    assign new_base_c = BASE_ADDR + AW'(fetch_row) * AW'(GRID_W);
    assign xfer_c     = read && !waitrequest;
    assign done_c     = (state_q == READ) && xfer_c && (col_q == COL_LAST);

    // Fetch sequencer; a stalled transfer is always completed before restarting.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            wr_bank_q  <= 1'b0;
            col_q      <= '0;
            row_base_q <= '0;
            address    <= '0;
            read       <= 1'b0;
            busy       <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            if (line_start) begin
                wr_bank_q  <= ~wr_bank_q;
                row_base_q <= new_base_c;
                col_q      <= '0;
            end

            if (line_start && (state_q != IDLE) && !done_c) begin
                underrun <= 1'b1;
            end else if (clear_err) begin
                underrun <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (line_start) begin
                        state_q <= READ;
                        address <= new_base_c;
                        read    <= 1'b1;
                        busy    <= 1'b1;
                    end
                end
                READ: begin
                    if (line_start) begin
                        if (xfer_c) begin
                            address <= new_base_c;
                        end else begin
                            state_q <= DRAIN;
                        end
                    end else if (xfer_c) begin
                        if (col_q == COL_LAST) begin
                            state_q <= IDLE;
                            read    <= 1'b0;
                            busy    <= 1'b0;
                        end else begin
                            col_q   <= col_q + CW'(1);
                            address <= row_base_q + AW'(col_q + CW'(1));
                        end
                    end
                end
                DRAIN: begin
                    // The drained byte is discarded; col was already zeroed on entry.
                    if (xfer_c) begin
                        state_q <= READ;
                        address <= line_start ? new_base_c : row_base_q;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    read    <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

    // Line buffer write side; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if ((state_q == READ) && xfer_c) begin
            if (wr_bank_q) begin
                bank1[col_q[IW-1:0]] <= readdata;
            end else begin
                bank0[col_q[IW-1:0]] <= readdata;
            end
        end
    end

    // Renderer read port on the display bank.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data <= 8'h00;
        end else if ({1'b0, rd_col} < COL_LIM) begin
            rd_data <= wr_bank_q ? bank0[rd_col[IW-1:0]] : bank1[rd_col[IW-1:0]];
        end else begin
            rd_data <= 8'h00;
        end
    end

endmodule

// File: tb/tb_line_fetch.sv
// Bench for line_fetch: directed scenarios with literal expectations, then random
// traffic checked every cycle against a transaction-level reference model.
module tb_line_fetch;

    localparam int unsigned G    = 8;
    localparam logic [22:0] BASE = 23'h100;

    logic        clk = 1'b0;
    logic        reset, line_start, clear_err, waitrequest;
    logic [8:0]  fetch_row;
    logic [9:0]  rd_col;
    logic [7:0]  readdata;
    logic [22:0] address;
    logic        read, busy, underrun;
    logic [7:0]  rd_data;

    always #10 clk = ~clk;

    line_fetch #(.GRID_W(G), .BASE_ADDR(BASE)) dut (
        .clk(clk), .reset(reset), .line_start(line_start), .fetch_row(fetch_row),
        .address(address), .read(read), .waitrequest(waitrequest), .readdata(readdata),
        .rd_col(rd_col), .rd_data(rd_data), .busy(busy), .underrun(underrun),
        .clear_err(clear_err)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    // Slave: data is the low address byte; stall mode 1 = fixed stalls per beat, 2 = random.
    int wr_mode = 0;
    int nstall  = 3;
    int scnt    = 0;
    bit rnd_w   = 1'b0;

    always_comb readdata = address[7:0];

    always_comb begin
        waitrequest = 1'b0;
        if (wr_mode == 1)      waitrequest = (scnt < nstall);
        else if (wr_mode == 2) waitrequest = rnd_w;
    end

    always @(posedge clk) begin
        if (reset)            scnt <= 0;
        else if (read)        scnt <= waitrequest ? scnt + 1 : 0;
    end

    // Reference model: a row fetch is a sequence of byte transfers, one per completed beat.
    int m_phase = 0;            // 0 idle, 1 fetching, 2 finishing an abandoned transfer
    int m_wbank = 0;
    int m_col = 0, m_base = 0, m_addr = 0, m_rd = 0;
    bit m_read = 0, m_under = 0, m_rd_known = 1;
    int m_mem [2][G];
    bit m_val [2][G];

    always @(posedge clk) begin
        bit done_beat, fetch_complete;
        int nb;
        if (reset) begin
            m_phase = 0; m_wbank = 0; m_col = 0; m_base = 0; m_addr = 0;
            m_read = 0; m_under = 0; m_rd = 0; m_rd_known = 1;
        end else begin
            if (int'(rd_col) >= int'(G)) begin
                m_rd = 0; m_rd_known = 1;
            end else begin
                m_rd = m_mem[1 - m_wbank][rd_col];
                m_rd_known = m_val[1 - m_wbank][rd_col];
            end
            done_beat = m_read && !waitrequest;
            if (m_phase == 1 && done_beat) begin
                m_mem[m_wbank][m_col] = m_addr % 256;
                m_val[m_wbank][m_col] = 1;
            end
            fetch_complete = (m_phase == 1) && done_beat && (m_col == int'(G) - 1);
            nb = (int'(BASE) + int'(fetch_row) * int'(G)) % (1 << 23);
            if (line_start && m_phase != 0 && !fetch_complete) m_under = 1;
            else if (clear_err) m_under = 0;
            if (line_start) begin
                m_wbank = 1 - m_wbank;
                m_base = nb;
                m_col = 0;
                if (m_phase == 0 || done_beat) begin
                    m_phase = 1; m_addr = nb; m_read = 1;
                end else begin
                    m_phase = 2;
                end
            end else if (done_beat) begin
                if (m_phase == 2) begin
                    m_phase = 1; m_addr = m_base;
                end else if (m_col == int'(G) - 1) begin
                    m_phase = 0; m_read = 0;
                end else begin
                    m_col = m_col + 1; m_addr = m_base + m_col;
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("m_read", int'(read), int'(m_read));
            check("m_busy", int'(busy), int'(m_phase != 0));
            check("m_underrun", int'(underrun), int'(m_under));
            if (m_read) check("m_address", int'(address), m_addr);
            if (m_rd_known) check("m_rd_data", int'(rd_data), m_rd);
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic pulse(input int row);
        line_start = 1'b1;
        fetch_row = 9'(row);
        tick();
        line_start = 1'b0;
    endtask

    task automatic wait_idle();
        int cnt = 0;
        while (busy && cnt < 200) begin
            tick();
            cnt++;
        end
        check("wait_idle", int'(busy), 0);
    endtask

    initial begin
        int cnt;
        reset = 1'b1; line_start = 1'b0; fetch_row = '0; clear_err = 1'b0; rd_col = '0;
        repeat (2) tick();
        chk_en = 1'b1;
        check("rst_read", int'(read), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_underrun", int'(underrun), 0);
        check("rst_address", int'(address), 0);
        check("rst_rd_data", int'(rd_data), 0);
        reset = 1'b0;
        tick();

        // Zero-wait fetch of row 2: 0x110..0x117 back to back.
        pulse(2);
        for (int i = 0; i < 8; i++) begin
            check("t1_addr", int'(address), 'h110 + i);
            check("t1_read", int'(read), 1);
            tick();
        end
        check("t1_done_read", int'(read), 0);
        check("t1_done_busy", int'(busy), 0);

        // Swap and sweep the display bank, including out-of-range columns.
        pulse(3);
        for (int i = 0; i < 10; i++) begin
            rd_col = 10'(i);
            tick();
            check("t2_rd", int'(rd_data), (i < 8) ? 'h10 + i : 0);
        end
        wait_idle();

        // Three stall cycles per beat.
        wr_mode = 1;
        pulse(2);
        cnt = 0;
        while (busy && cnt < 100) begin
            cnt++;
            tick();
        end
        check("t3_busy_cycles", cnt, 32);
        pulse(4);
        for (int i = 0; i < 8; i++) begin
            rd_col = 10'(i);
            tick();
            check("t3_rd", int'(rd_data), 'h10 + i);
        end
        wait_idle();

        // line_start during a stall at col 4 drains then refetches row 5.
        pulse(2);
        repeat (16) tick();
        check("t4_addr_col4", int'(address), 'h114);
        line_start = 1'b1; fetch_row = 9'd5;
        tick();
        line_start = 1'b0;
        check("t4_underrun", int'(underrun), 1);
        check("t4_hold_read", int'(read), 1);
        check("t4_hold_addr", int'(address), 'h114);
        cnt = 0;
        while (address == 23'h114 && cnt < 20) begin
            tick();
            cnt++;
        end
        check("t4_refetch_addr", int'(address), 'h128);
        check("t4_drain_cycles", cnt, 3);
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        check("t4_cleared", int'(underrun), 0);
        wait_idle();

        // line_start on the last-byte completion cycle is not an underrun.
        wr_mode = 0;
        pulse(2);
        repeat (7) tick();
        line_start = 1'b1; fetch_row = 9'd1;
        tick();
        line_start = 1'b0;
        check("t5_underrun", int'(underrun), 0);
        check("t5_read", int'(read), 1);
        check("t5_addr", int'(address), 'h108);

        // Mid-fetch underrun, then synchronous reset mid-READ.
        repeat (2) tick();
        pulse(3);
        check("t6_underrun_set", int'(underrun), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t6_rst_read", int'(read), 0);
        check("t6_rst_busy", int'(busy), 0);
        check("t6_rst_underrun", int'(underrun), 0);
        pulse(0);
        clear_err = 1'b1; line_start = 1'b1; fetch_row = 9'd6;
        tick();
        clear_err = 1'b0; line_start = 1'b0;
        check("t6_set_wins", int'(underrun), 1);

        // Random traffic against the model.
        wr_mode = 2;
        for (int i = 0; i < 4000; i++) begin
            rnd_w      = ($urandom_range(0, 9) < 4);
            line_start = ($urandom_range(0, 19) == 0);
            fetch_row  = 9'($urandom_range(0, 511));
            clear_err  = ($urandom_range(0, 15) == 0);
            rd_col     = 10'($urandom_range(0, 11));
            reset      = ($urandom_range(0, 599) == 0);
            tick();
        end
        reset = 1'b0; line_start = 1'b0; clear_err = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
